svc_soc_io_arb: RTL



---
 rtl/svc_soc_io_arb_pkg.sv | 18 +
 rtl/svc_soc_io_arb_if.sv | 44 ++++
 rtl/svc_rr_arb2.sv | 22 ++
 rtl/svc_soc_io_arb.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/svc_soc_io_arb_pkg.sv
// Shared types and sizes for the two-requester MMIO arbiter.
package svc_soc_io_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned GRANT_W = 1;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;

  typedef logic [GRANT_W-1:0] grant_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/svc_soc_io_arb_if.sv
// Requester and register-bank signals of the MMIO arbiter.
// req_lock exists only when SVC_SOC_IO_ARB_LOCK_EN is defined.
interface svc_soc_io_arb_if;
  import svc_soc_io_arb_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0][STRB_W-1:0] req_wstrb;
`ifdef SVC_SOC_IO_ARB_LOCK_EN
  logic [NUM_REQ-1:0]             req_lock;
`endif
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           io_wen;
  logic [ADDR_W-1:0]              io_waddr;
  logic [DATA_W-1:0]              io_wdata;
  logic [STRB_W-1:0]              io_wstrb;
  logic                           io_ren;
  logic [ADDR_W-1:0]              io_raddr;
  logic [DATA_W-1:0]              io_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, io_rdata,
`ifdef SVC_SOC_IO_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, rsp_valid, rsp_rdata,
    output io_wen, io_waddr, io_wdata, io_wstrb, io_ren, io_raddr
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, io_rdata,
`ifdef SVC_SOC_IO_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, rsp_valid, rsp_rdata,
    input  io_wen, io_waddr, io_wdata, io_wstrb, io_ren, io_raddr
  );

endinterface

// File: rtl/svc_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the requester
// that did not win last time is chosen.
module svc_rr_arb2
  import svc_soc_io_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  grant_idx_t         last_grant_i,
  output logic               grant_valid_o,
  output grant_idx_t         grant_idx_o
);

  always_comb begin
    grant_valid_o = |valid_i;
    grant_idx_o   = '0;
    case (valid_i)
      2'b10:   grant_idx_o = grant_idx_t'(1);
      2'b11:   grant_idx_o = ~last_grant_i;
      default: grant_idx_o = '0;
    endcase
  end

endmodule

// File: rtl/svc_soc_io_arb.sv
// Two-requester arbiter/sequencer in front of the MMIO register bank, one
// transaction outstanding. Optional lock for atomic RMW: SVC_SOC_IO_ARB_LOCK_EN.
module svc_soc_io_arb
  import svc_soc_io_arb_pkg::*;
#(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  svc_soc_io_arb_if.slave bus
);

  if (RD_LATENCY > 1 || LOCK_TIMEOUT == 0) begin : g_param_check
    $error("svc_soc_io_arb: RD_LATENCY must be 0 or 1 and LOCK_TIMEOUT nonzero");
  end

  state_e             state_q, state_d;
  grant_idx_t         grant_q, grant_d;
  grant_idx_t         last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] arb_valid;
  logic               pick_valid;
  grant_idx_t         pick_idx;

  svc_rr_arb2 u_rr (
    .valid_i       (arb_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (pick_valid),
    .grant_idx_o   (pick_idx)
  );

`ifdef SVC_SOC_IO_ARB_LOCK_EN
  localparam int unsigned LOCK_CW = $clog2(LOCK_TIMEOUT + 1);

  logic               lock_q, lock_d;
  grant_idx_t         lock_owner_q, lock_owner_d;
  logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d;

  // Lock follows req_lock at each handshake; idle owner times it out.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    if (state_q == RESP && bus.rsp_ready[grant_q]) begin
      lock_d       = bus.req_lock[grant_q];
      lock_owner_d = grant_q;
      lock_cnt_d   = '0;
    end else if (state_q == IDLE && lock_q) begin
      if (bus.req_valid[lock_owner_q]) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LOCK_CW'(LOCK_TIMEOUT - 1)) begin
        lock_d     = 1'b0;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + LOCK_CW'(1);
      end
    end
  end

  assign arb_valid = lock_q ? (bus.req_valid & (NUM_REQ'(1) << lock_owner_q)) : bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end
`else
  assign arb_valid = bus.req_valid;
`endif

  // Sequencer; all strobes and accepts are suppressed while rst is high.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    rdata_d       = rdata_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.io_wen    = 1'b0;
    bus.io_waddr  = '0;
    bus.io_wdata  = '0;
    bus.io_wstrb  = '0;
    bus.io_ren    = 1'b0;
    bus.io_raddr  = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            bus.req_ready[pick_idx] = 1'b1;
            grant_d      = pick_idx;
            last_grant_d = pick_idx;
            if (bus.req_write[pick_idx]) begin
              bus.io_wen   = 1'b1;
              bus.io_waddr = bus.req_addr[pick_idx];
              bus.io_wdata = bus.req_wdata[pick_idx];
              bus.io_wstrb = bus.req_wstrb[pick_idx];
              rdata_d      = '0;
              state_d      = RESP;
            end else begin
              bus.io_ren   = 1'b1;
              bus.io_raddr = bus.req_addr[pick_idx];
              if (RD_LATENCY == 0) begin
                rdata_d = bus.io_rdata;
                state_d = RESP;
              end else begin
                state_d = RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          rdata_d = bus.io_rdata;
          state_d = RESP;
        end
        RESP: begin
          bus.rsp_valid[grant_q] = 1'b1;
          if (bus.rsp_ready[grant_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= grant_idx_t'(1);
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
